// File: rtl/aes_pkg.sv
// Shared AES constants: key-length encoding, Nk/Nr lookups, xtime and the
// forward S-box used by both the key schedule and the round datapath.
package aes_pkg;

  localparam logic [1:0] KEY_LEN_128 = 2'd0;
  localparam logic [1:0] KEY_LEN_192 = 2'd1;
  localparam logic [1:0] KEY_LEN_256 = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_READY} state_t;

  // Nk in 32-bit words; 0 marks the reserved encoding.
  function automatic logic [3:0] nk_of(input logic [1:0] len);
    case (len)
      KEY_LEN_128: nk_of = 4'd4;
      KEY_LEN_192: nk_of = 4'd6;
      KEY_LEN_256: nk_of = 4'd8;
      default:     nk_of = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] len);
    case (len)
      KEY_LEN_128: nr_of = 4'd10;
      KEY_LEN_192: nr_of = 4'd12;
      KEY_LEN_256: nr_of = 4'd14;
      default:     nr_of = 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel combinational S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] data,
  output logic [31:0] result
);

  assign result = {SBOX[data[31:24]], SBOX[data[23:16]],
                   SBOX[data[15:8]],  SBOX[data[7:0]]};

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key schedule: one word per cycle into a round-key
// store with a registered read port. Define KEYEXP_ZEROIZE_EN for zeroize.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef KEYEXP_ZEROIZE_EN
  input  logic                    zeroize,
`endif
  input  logic                    start,
  input  logic [1:0]              key_len,
  input  logic [MAX_KEY_BITS-1:0] key_in,
  output logic                    busy,
  output logic                    ready,
  output logic                    cfg_err,
  input  logic                    rd_en,
  input  logic [3:0]              rd_round,
  output logic [127:0]            rd_key,
  output logic                    rd_valid,
  output logic                    rd_err
);

  localparam int KW_NUM = MAX_KEY_BITS / 32;
  localparam int DEPTH  = 4 * (KW_NUM + 7);

  state_t      state_q, state_d;
  logic [1:0]  len_q;
  logic [5:0]  idx_q;
  logic [2:0]  mod_q;
  logic [7:0]  rcon_q;
  logic [31:0] win [8];
  logic [31:0] win_d [8];
  logic [31:0] win_load [8];
  logic [31:0] store [DEPTH];
  logic        store_we [DEPTH];
  logic [31:0] store_wd [DEPTH];
  logic [31:0] kw [KW_NUM];

  logic        wipe, load, cfg_err_d, expand_wr, last_word, start_legal, rd_ok;
  logic [3:0]  nk_in, nk_cur, nr_cur;
  logic [5:0]  nw_cur, rd_base;
  logic [31:0] prev, oldest, sub_in, sub_out, temp, new_word;

`ifdef KEYEXP_ZEROIZE_EN
  assign wipe = zeroize;
`else
  assign wipe = 1'b0;
`endif

  assign nk_in       = nk_of(key_len);
  assign nk_cur      = nk_of(len_q);
  assign nr_cur      = nr_of(len_q);
  assign nw_cur      = {nr_cur, 2'b00} + 6'd4;
  assign start_legal = (nk_in != 4'd0) && (int'(nk_in) * 32 <= MAX_KEY_BITS);
  assign last_word   = (idx_q == nw_cur - 6'd1);
  assign expand_wr   = (state_q == ST_EXPAND) && !wipe;
  assign busy        = (state_q == ST_EXPAND);
  assign ready       = (state_q == ST_READY);
  assign rd_ok       = rd_en && ready && !start && !wipe && (rd_round <= nr_cur);
  assign rd_base     = {rd_round, 2'b00};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d   = state_q;
    load      = 1'b0;
    cfg_err_d = 1'b0;
    if (start && state_q != ST_EXPAND) begin
      if (start_legal) load = 1'b1;
      else             cfg_err_d = 1'b1;
    end
    if (load)                                   state_d = ST_EXPAND;
    else if (state_q == ST_EXPAND && last_word) state_d = ST_READY;
    if (wipe) begin
      state_d   = ST_IDLE;
      load      = 1'b0;
      cfg_err_d = 1'b0;
    end
  end

  // Word datapath: the window is right-aligned, win[7] = w[i-1].
  assign prev   = win[7];
  assign oldest = (nk_cur == 4'd4) ? win[4] : (nk_cur == 4'd6) ? win[2] : win[0];
  assign sub_in = (mod_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  aes_sub_word u_sub_word (.data(sub_in), .result(sub_out));

  always_comb begin
    temp = prev;
    if (mod_q == 3'd0)                         temp = sub_out ^ {rcon_q, 24'h0};
    else if (nk_cur == 4'd8 && mod_q == 3'd4)  temp = sub_out;
  end
  assign new_word = oldest ^ temp;

  always_comb begin
    for (int j = 0; j < KW_NUM; j++) kw[j] = key_in[MAX_KEY_BITS-1-32*j -: 32];
    for (int k = 0; k < 8; k++) begin
      win_load[k] = '0;
      for (int j = 0; j < KW_NUM; j++)
        if (j == k - 8 + int'(nk_in)) win_load[k] = kw[j];
      win_d[k] = win[k];
      if (load)           win_d[k] = win_load[k];
      else if (expand_wr) win_d[k] = (k == 7) ? new_word : win[(k + 1) % 8];
    end
    for (int k = 0; k < DEPTH; k++) begin
      store_we[k] = expand_wr && (int'(idx_q) == k);
      store_wd[k] = new_word;
    end
    for (int j = 0; j < KW_NUM; j++) begin
      if (load && j < int'(nk_in)) begin
        store_we[j] = 1'b1;
        store_wd[j] = kw[j];
      end
    end
  end

`ifdef KEYEXP_ZEROIZE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || wipe) begin
      for (int k = 0; k < DEPTH; k++) store[k] <= '0;
      for (int k = 0; k < 8; k++)     win[k]   <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) if (store_we[k]) store[k] <= store_wd[k];
      for (int k = 0; k < 8; k++)     win[k] <= win_d[k];
    end
  end
`else
  // NOTE: the key store and window carry no reset; their contents only matter once written.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) if (store_we[k]) store[k] <= store_wd[k];
    for (int k = 0; k < 8; k++)     win[k] <= win_d[k];
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      len_q    <= KEY_LEN_128;
      idx_q    <= '0;
      mod_q    <= '0;
      rcon_q   <= 8'h01;
      cfg_err  <= 1'b0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_key   <= '0;
    end else begin
      state_q  <= state_d;
      cfg_err  <= cfg_err_d;
      rd_valid <= rd_ok;
      rd_err   <= rd_en && !rd_ok && !wipe;
      if (wipe)
        rd_key <= '0;
      else if (rd_ok)
        rd_key <= {store[rd_base], store[rd_base + 6'd1],
                   store[rd_base + 6'd2], store[rd_base + 6'd3]};
      if (load) begin
        len_q  <= key_len;
        idx_q  <= {2'b00, nk_in};
        mod_q  <= '0;
        rcon_q <= 8'h01;
      end else if (expand_wr) begin
        idx_q <= idx_q + 6'd1;
        mod_q <= ({1'b0, mod_q} == nk_cur - 4'd1) ? 3'd0 : mod_q + 3'd1;
        if (mod_q == 3'd0) rcon_q <= xtime(rcon_q);
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: FIPS-197 vector table, scoreboarded
// reads, and hand sequences for restart, ignore, error and reset corner cases.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key_in = '0;
  logic         busy, ready, cfg_err;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_round = 4'd0;
  logic [127:0] rd_key;
  logic         rd_valid, rd_err;
`ifdef KEYEXP_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  logic [127:0] sb [$];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  typedef struct {
    logic [1:0]   len;
    logic [255:0] key;
    int           latency;
    logic [3:0]   round;
    bit           ok;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [10];

  aes_key_expander #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef KEYEXP_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .ready(ready), .cfg_err(cfg_err),
    .rd_en(rd_en), .rd_round(rd_round), .rd_key(rd_key),
    .rd_valid(rd_valid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Starts an expansion and counts edges until ready; optionally pokes a
  // second start or a read at a given cycle of the expansion.
  task automatic run_expand(input logic [1:0] len, input logic [255:0] key, input int exp_lat,
                            input int poke_start, input int poke_read, input string name);
    int cnt;
    @(negedge clk);
    start = 1'b1; key_len = len; key_in = key;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 1;
    check({name, "_busy_up"}, busy, 1'b1);
    check({name, "_ready_drop"}, ready, 1'b0);
    while (!ready && cnt < 200) begin
      if (cnt == poke_start) begin
        start = 1'b1; key_len = 2'd2; key_in = K256;
      end
      if (cnt == poke_read) begin
        rd_en = 1'b1; rd_round = 4'd0;
      end
      @(posedge clk); #1;
      if (cnt == poke_read) begin
        check({name, "_rd_err_expand"}, rd_err, 1'b1);
        check({name, "_rd_valid_expand"}, rd_valid, 1'b0);
      end
      start = 1'b0; rd_en = 1'b0;
      cnt++;
    end
    check({name, "_latency"}, cnt, exp_lat);
    check({name, "_busy_done"}, busy, 1'b0);
  endtask

  task automatic do_read(input logic [3:0] round, input bit ok, input logic [127:0] exp,
                         input string name);
    logic [127:0] prev;
    logic [127:0] want;
    @(negedge clk);
    prev = rd_key;
    rd_en = 1'b1; rd_round = round;
    if (ok) sb.push_back(exp);
    @(posedge clk); #1;
    rd_en = 1'b0;
    check({name, "_valid"}, rd_valid, ok);
    check({name, "_err"}, rd_err, !ok);
    if (rd_valid) begin
      if (sb.size() == 0) begin
        check({name, "_unexpected_data"}, 1'b1, 1'b0);
      end else begin
        want = sb.pop_front();
        check({name, "_key"}, rd_key, want);
      end
    end else begin
      if (ok && sb.size() > 0) void'(sb.pop_back());
      check({name, "_key_held"}, rd_key, prev);
    end
  endtask

  initial begin
    vecs[0] = '{2'd0, K128, 41, 4'd0,  1'b1, K128[255:128]};
    vecs[1] = '{2'd0, K128, 41, 4'd1,  1'b1, 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{2'd0, K128, 41, 4'd10, 1'b1, R10_128};
    vecs[3] = '{2'd0, K128, 41, 4'd11, 1'b0, 128'h0};
    vecs[4] = '{2'd1, K192, 47, 4'd0,  1'b1, 128'h8e73b0f7da0e6452c810f32b809079e5};
    vecs[5] = '{2'd1, K192, 47, 4'd12, 1'b1, 128'he98ba06f448c773c8ecc720401002202};
    vecs[6] = '{2'd1, K192, 47, 4'd13, 1'b0, 128'h0};
    vecs[7] = '{2'd2, K256, 53, 4'd0,  1'b1, 128'h603deb1015ca71be2b73aef0857d7781};
    vecs[8] = '{2'd2, K256, 53, 4'd1,  1'b1, 128'h1f352c073b6108d72d9810a30914dff4};
    vecs[9] = '{2'd2, K256, 53, 4'd14, 1'b1, R14_256};

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_err", rd_err, 1'b0);
    check("rst_rd_key", rd_key, 128'h0);

    // Reserved key_len in IDLE: one-cycle cfg_err, FSM stays idle.
    @(negedge clk);
    start = 1'b1; key_len = 2'd3; key_in = K128;
    @(posedge clk); #1;
    start = 1'b0;
    check("cfg_err_pulse", cfg_err, 1'b1);
    check("cfg_err_busy", busy, 1'b0);
    @(posedge clk); #1;
    check("cfg_err_clear", cfg_err, 1'b0);
    check("cfg_err_idle", {busy, ready}, 2'b00);

    do_read(4'd0, 1'b0, 128'h0, "rd_idle");

    for (int i = 0; i < 10; i++) begin
      if (i == 0 || vecs[i].key != vecs[i-1].key)
        run_expand(vecs[i].len, vecs[i].key, vecs[i].latency, 0, 0,
                   $sformatf("exp_len%0d", vecs[i].len));
      do_read(vecs[i].round, vecs[i].ok, vecs[i].exp,
              $sformatf("vec%0d_len%0d_r%0d", i, vecs[i].len, vecs[i].round));
    end

    // Reserved key_len in READY: error pulse, schedule stays ready.
    @(negedge clk);
    start = 1'b1; key_len = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("ready_cfg_err", cfg_err, 1'b1);
    check("ready_cfg_keep", ready, 1'b1);
    do_read(4'd14, 1'b1, R14_256, "ready_after_cfg_err");

    // Restart with a simultaneous read: read rejected, restart proceeds.
    @(negedge clk);
    start = 1'b1; key_len = 2'd0; key_in = K128; rd_en = 1'b1; rd_round = 4'd0;
    @(posedge clk); #1;
    start = 1'b0; rd_en = 1'b0;
    check("simul_rd_err", rd_err, 1'b1);
    check("simul_rd_valid", rd_valid, 1'b0);
    check("simul_busy", busy, 1'b1);
    begin
      int cnt = 1;
      while (!ready && cnt < 200) begin
        @(posedge clk); #1;
        cnt++;
      end
      check("simul_latency", cnt, 41);
    end
    do_read(4'd10, 1'b1, R10_128, "simul_r10");

    // Start ignored mid-expansion, read rejected mid-expansion.
    run_expand(2'd2, K256, 53, 0, 0, "pre256");
    run_expand(2'd0, K128, 41, 10, 5, "ignore");
    do_read(4'd10, 1'b1, R10_128, "ignore_r10");
    do_read(4'd0, 1'b1, K128[255:128], "ignore_r0");

    // Asynchronous reset in the middle of an expansion.
    @(negedge clk);
    start = 1'b1; key_len = 2'd0; key_in = K128;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_ready", ready, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", {busy, ready}, 2'b00);
    run_expand(2'd0, K128, 41, 0, 0, "after_rst");
    do_read(4'd10, 1'b1, R10_128, "after_rst_r10");

`ifdef KEYEXP_ZEROIZE_EN
    @(negedge clk) zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    check("zeroize_ready", ready, 1'b0);
    check("zeroize_busy", busy, 1'b0);
    check("zeroize_rd_key", rd_key, 128'h0);
    do_read(4'd10, 1'b0, 128'h0, "zeroize_read");
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Sequential, parametrised AES key-schedule engine supporting AES-128/192/256. It replaces the fully combinational 128-bit round-key generator. On `start` it expands the cipher key one 32-bit word per cycle into an internal round-key store, then serves any round key by index through a registered read port to the encrypt/decrypt round datapath.

## Interface
- `MAX_KEY_BITS`, default 256: widest supported key (128, 192 or 256). Sets the `key_in` width and the store depth of 4·(Nr_max+1) words (44/52/60).
- `clk`  in  1  system clock
- `rst_n`  in  1  reset (decided: one clock; reset is asynchronous and active-low)
- `start`  in  1  begin expansion; sampled with `key_len`/`key_in`
- `key_len`  in  2  0=128, 1=192, 2=256, 3=reserved
- `key_in`  in  MAX_KEY_BITS  cipher key, left-justified; w0 = `key_in[MAX_KEY_BITS-1 -: 32]`
- `busy`  out  1  expansion in progress
- `ready`  out  1  store holds a complete schedule
- `cfg_err`  out  1  one-cycle pulse: illegal `key_len` at `start`
- `rd_en`  in  1  read request
- `rd_round`  in  4  round index 0..Nr
- `rd_key`  out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in [127:96]
- `rd_valid`  out  1  `rd_key` valid (one-cycle pulse)
- `rd_err`  out  1  one-cycle pulse: read rejected

## Operation
- Nk = 4/6/8 and Nr = 10/12/14 for `key_len` 0/1/2. Nw = 4·(Nr+1) = 44/52/60.
- FSM states:
  - IDLE → EXPAND when `start` is high and `key_len` is legal.
  - EXPAND → READY after writing w[Nw-1].
  - READY → EXPAND on a legal `start` (restart). This clears `ready` immediately.
- `start` with `key_len`=3, or a `key_len` whose Nk·32 exceeds `MAX_KEY_BITS`: `cfg_err` pulses and the state is unchanged.
- `start` during EXPAND is ignored. No error is raised.
- Start cycle: Nk words are loaded into the store and a sliding window of the last Nk words. `rcon` is set to 8'h01. The mod-Nk counter is cleared. The index is set to i=Nk.
- Each EXPAND cycle computes one word, per FIPS-197:
  - temp = w[i-1].
  - If i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon), giving 01,02,…,80,1b,36.
  - Else if Nk = 8 and i mod 8 = 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
- No division or modulo hardware: a wrapping mod-Nk counter drives the i mod Nk tests.
- Read port:
  - `rd_en` in READY with `rd_round` ≤ Nr: `rd_key` and `rd_valid` are updated next cycle.
  - `rd_en` in any other state, or with `rd_round` > Nr: `rd_err` pulses next cycle and `rd_key` holds its previous value.
- Simultaneous `start` and `rd_en` in READY: the read is rejected (`rd_err`) and the restart proceeds.

## Timing
- Reset values: all outputs 0, state IDLE, `rcon` 8'h01. Store contents are don't-care unless `KEYEXP_ZEROIZE_EN` is defined.
- `busy` is high from the cycle after `start` through the final write cycle.
- `ready` rises the cycle after w[Nw-1] is written.
- `start` → `ready` latency is Nw−Nk+1 cycles: 41 / 47 / 53 for 128 / 192 / 256.
- Read latency is 1 cycle. One read per cycle is supported.
- `rst_n` asserted mid-EXPAND: FSM goes to IDLE asynchronously. A new `start` is required after release.

## Configuration
- `KEYEXP_ZEROIZE_EN` defined:
  - Adds input `zeroize` (1 bit). Asserting it clears all store words, the window and `rd_key` to 0 in one cycle, forces IDLE and drops `busy`/`ready`.
  - `zeroize` has priority over `start` and `rd_en`.
  - `rst_n` also clears the store.
- `KEYEXP_ZEROIZE_EN` undefined: no `zeroize` port. The store has no reset and retains key material until overwritten.

## Structure
- Shared package `aes_pkg` holds:
  - `key_len` encoding constants.
  - Nk/Nr lookup functions.
  - the xtime function.
  - the 256-entry S-box constant, also used by the round datapath.
- One sub-module, `aes_sub_word`: 32-bit SubWord, four parallel combinational S-box lookups.
- The FSM, the counters and the store live in the top module.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - `ready` is observed 41 cycles after `start`.
  - round 0 reads the key back.
  - round 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b (left-justified):
  - `ready` after 47 cycles.
  - round 12 reads e98ba06f448c773c8ecc720401002202.
  - `rd_round`=13 gives `rd_err`=1 and `rd_valid`=0.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - `ready` after 53 cycles.
  - round 14 reads fe4890d1e6188d0b046df344706c631e.
- Error and ignore cases:
  - `key_len`=3 gives a one-cycle `cfg_err` and the FSM stays IDLE.
  - `start` at cycle 10 of an expansion is ignored and the final keys match the first key.
  - `rd_en` during EXPAND gives `rd_err`.
- `rst_n` pulsed at cycle 20 of an AES-128 expansion:
  - `busy`/`ready` go to 0 asynchronously.
  - Re-`start` yields correct round-10 keys after 41 cycles.
- With `KEYEXP_ZEROIZE_EN` defined, `zeroize` in READY:
  - `ready`=0.
  - `rd_key`=0.
  - the next read gives `rd_err`.
